// File: rtl/nios_system_cpu_0_oci_pkg.sv
// Shared OCI definitions: DCT frame layout, frame type codes, sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package nios_system_cpu_0_oci_pkg;

    localparam int DCT_TYPE_W  = 2;
    localparam int DCT_CNT_W   = 4;
    localparam int DCT_BUF_W   = 30;
    localparam int DCT_FRAME_W = DCT_TYPE_W + DCT_CNT_W + DCT_BUF_W;
    localparam int DCT_CODES   = DCT_BUF_W / 2;

    localparam logic [DCT_TYPE_W-1:0] DCT_T_FULL  = 2'b01;
    localparam logic [DCT_TYPE_W-1:0] DCT_T_FLUSH = 2'b10;
    localparam logic [DCT_TYPE_W-1:0] DCT_T_OVF   = 2'b11;

    typedef struct packed {
        logic [DCT_TYPE_W-1:0] ftype;
        logic [DCT_CNT_W-1:0]  count;
        logic [DCT_BUF_W-1:0]  buffer;
    } dct_frame_t;

    typedef enum logic {
        FL_IDLE    = 1'b0,
        FL_PENDING = 1'b1
    } dct_flush_state_t;

    function automatic dct_frame_t dct_make_frame(
        input logic [DCT_TYPE_W-1:0] ftype,
        input logic [DCT_CNT_W-1:0]  count,
        input logic [DCT_BUF_W-1:0]  buffer
    );
        dct_frame_t f;
        f.ftype  = ftype;
        f.count  = count;
        f.buffer = buffer;
        return f;
    endfunction

endpackage

// File: rtl/nios_system_cpu_0_oci_dct_slot.sv
// Single-entry output register for DCT frames with valid/ready handshake.
// Latency: a loaded frame is visible the cycle after load.
// Backpressure: holds frame stable while frame_ready is low; slot_free lets a new frame replace an accepted one.
module nios_system_cpu_0_oci_dct_slot
    import nios_system_cpu_0_oci_pkg::*;
#(
    parameter int FRAME_W = DCT_FRAME_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               frame_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               slot_free
);

    // Free when empty, or when the held frame is being accepted this cycle.
    assign slot_free = !frame_valid || frame_ready;

    // Slot register: load wins over drain so frames can go back-to-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            frame_data  <= load_data;
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios_system_cpu_0_oci_dct_sequencer.sv
// Packs 2-bit DCT branch codes into 30-bit buffers and emits 36-bit trace frames (full or flushed).
// Latency: frame visible one cycle after the transfer condition; 15th code in cycle N gives frame_valid in N+2.
// Backpressure: frame_ready stalls the slot; a full buffer behind a busy slot drops codes and sets overflow.
// Optional: DCT_OVERFLOW_COUNT_EN adds the saturating overflow_count port and the 2'b11 frame type.
module nios_system_cpu_0_oci_dct_sequencer
    import nios_system_cpu_0_oci_pkg::*;
#(
    parameter int FRAME_W = DCT_FRAME_W,
    parameter int CODES   = DCT_CODES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trace_enable,
    input  logic                 dct_code_valid,
    input  logic [1:0]           dct_code,
    input  logic                 flush,
    output logic                 frame_valid,
    output logic [FRAME_W-1:0]   frame_data,
    input  logic                 frame_ready,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 overflow
`ifdef DCT_OVERFLOW_COUNT_EN
    ,
    output logic [7:0]           overflow_count
`endif
);

    logic             trace_en_q;
    logic             en_rise;
    logic             en_fall;
    logic             flush_req;
    logic             code_in;
    logic             full;
    logic             slot_free;
    logic             xfer_full;
    logic             xfer_flush;
    logic             xfer;
    logic             accept;
    logic             drop;
    logic [DCT_BUF_W-1:0] buf_nxt;
    logic [DCT_CNT_W-1:0] cnt_nxt;
    logic [DCT_TYPE_W-1:0] frame_type;
    dct_frame_t       frame_nxt;
    dct_flush_state_t fl_state;
    dct_flush_state_t fl_nxt;
`ifdef DCT_OVERFLOW_COUNT_EN
    logic             ovf_mark;
`endif

    assign en_rise   = trace_enable && !trace_en_q;
    assign en_fall   = !trace_enable && trace_en_q;
    assign flush_req = flush || en_fall;
    assign code_in   = trace_enable && dct_code_valid;
    assign full      = (dct_count == DCT_CNT_W'(CODES));

    // A full buffer always takes priority; a pending flush only moves a non-empty partial buffer.
    assign xfer_full  = full && slot_free;
    assign xfer_flush = !full && (fl_state == FL_PENDING) && slot_free && (dct_count != '0);
    assign xfer       = xfer_full || xfer_flush;
    assign accept     = code_in && (!full || xfer_full);
    assign drop       = code_in && full && !slot_free;

    // Frame type selection; the first frame after a drop is tagged when counting is enabled.
    always_comb begin
        frame_type = xfer_full ? DCT_T_FULL : DCT_T_FLUSH;
`ifdef DCT_OVERFLOW_COUNT_EN
        if (ovf_mark) begin
            frame_type = DCT_T_OVF;
        end
`endif
        frame_nxt = dct_make_frame(frame_type, dct_count, dct_buffer);
    end

    // Next buffer/count: a transfer restarts the buffer, seeded by any code arriving that cycle.
    always_comb begin
        buf_nxt = dct_buffer;
        cnt_nxt = dct_count;
        if (xfer) begin
            buf_nxt = accept ? {{(DCT_BUF_W-2){1'b0}}, dct_code} : '0;
            cnt_nxt = accept ? DCT_CNT_W'(1) : '0;
        end else if (accept) begin
            buf_nxt = {dct_buffer[DCT_BUF_W-3:0], dct_code};
            cnt_nxt = dct_count + DCT_CNT_W'(1);
        end
    end

    // Flush state: any transfer satisfies a pending flush; flushing an empty buffer is ignored.
    always_comb begin
        fl_nxt = fl_state;
        case (fl_state)
            FL_IDLE: begin
                if (flush_req && (dct_count != '0) && !xfer) begin
                    fl_nxt = FL_PENDING;
                end
            end
            FL_PENDING: begin
                if (xfer || (dct_count == '0)) begin
                    fl_nxt = FL_IDLE;
                end
            end
            default: fl_nxt = FL_IDLE;
        endcase
    end

    // Packing buffer, fill count, flush state and enable history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            fl_state   <= FL_IDLE;
            trace_en_q <= 1'b0;
        end else begin
            dct_buffer <= buf_nxt;
            dct_count  <= cnt_nxt;
            fl_state   <= fl_nxt;
            trace_en_q <= trace_enable;
        end
    end

    // Sticky overflow, cleared when tracing is re-enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (en_rise) begin
            overflow <= drop;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef DCT_OVERFLOW_COUNT_EN
    // Saturating drop counter and the tag for the next loaded frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
            ovf_mark       <= 1'b0;
        end else begin
            if (en_rise) begin
                overflow_count <= drop ? 8'd1 : 8'd0;
            end else if (drop && (overflow_count != 8'hFF)) begin
                overflow_count <= overflow_count + 8'd1;
            end
            if (drop) begin
                ovf_mark <= 1'b1;
            end else if (xfer) begin
                ovf_mark <= 1'b0;
            end
        end
    end
`endif

    nios_system_cpu_0_oci_dct_slot #(
        .FRAME_W (FRAME_W)
    ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (xfer),
        .load_data   (FRAME_W'(frame_nxt)),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .slot_free   (slot_free)
    );

endmodule

// File: tb/tb_nios_system_cpu_0_oci_dct_sequencer.sv
module tb_nios_system_cpu_0_oci_dct_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_enable;
    logic        dct_code_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        frame_valid;
    logic [35:0] frame_data;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
`ifdef DCT_OVERFLOW_COUNT_EN
    logic [7:0]  overflow_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [35:0] fq[$];
    int          fc[$];

    nios_system_cpu_0_oci_dct_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trace_enable   (trace_enable),
        .dct_code_valid (dct_code_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow)
`ifdef DCT_OVERFLOW_COUNT_EN
        ,
        .overflow_count (overflow_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every accepted frame with the cycle it was accepted in.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
            fq.push_back(frame_data);
            fc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trace_enable = 1'b0; dct_code_valid = 1'b0;
        dct_code = 2'b00; flush = 1'b0; frame_ready = 1'b0;
        step(); step();
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_count got %h want 0", dct_count); end
        checks++; if (dct_buffer !== 30'd0) begin errors++; $display("FAIL reset_buffer got %h want 0", dct_buffer); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        checks++; if (frame_data !== 36'd0) begin errors++; $display("FAIL reset_data got %h want 0", frame_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`ifdef DCT_OVERFLOW_COUNT_EN
        checks++; if (overflow_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got %h want 0", overflow_count); end
`endif
        reset_n = 1'b1;
        step();
        trace_enable = 1'b1; frame_ready = 1'b1;
        step(); step();
    endtask

    task automatic test_fill();
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            dct_code_valid = 1'b1; dct_code = 2'b01; step();
        end
        checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL fill_count15 got %0d want 15", dct_count); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL fill_latency_n1 got %b want 0", frame_valid); end
        dct_code_valid = 1'b0;
        step();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fill_latency_n2 got %b want 1", frame_valid); end
        checks++; if (frame_data !== {2'b01, 4'hF, 30'h15555555}) begin errors++; $display("FAIL fill_frame got %h want %h", frame_data, {2'b01, 4'hF, 30'h15555555}); end
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL fill_count_clear got %0d want 0", dct_count); end
        step();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_drop got %b want 0", frame_valid); end
        // Sixteenth code lands in the transfer cycle and seeds the next buffer.
        for (int i = 0; i < 16; i++) begin
            dct_code_valid = 1'b1; dct_code = (i == 15) ? 2'b10 : 2'b01; step();
        end
        dct_code_valid = 1'b0;
        checks++; if (dct_count !== 4'd1) begin errors++; $display("FAIL fill16_count got %0d want 1", dct_count); end
        checks++; if (dct_buffer !== 30'h2) begin errors++; $display("FAIL fill16_buffer got %h want 2", dct_buffer); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fill16_valid got %b want 1", frame_valid); end
        flush = 1'b1; step(); flush = 1'b0; step();
        checks++; if (frame_data !== {2'b10, 4'd1, 30'h2} || frame_valid !== 1'b1) begin errors++; $display("FAIL fill16_flush_frame got %h v=%b want %h", frame_data, frame_valid, {2'b10, 4'd1, 30'h2}); end
        step();
    endtask

    task automatic test_flush();
        logic [1:0] seq [3];
        int n0;
        seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b01;
        frame_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dct_code_valid = 1'b1; dct_code = seq[i]; step();
        end
        dct_code_valid = 1'b0;
        flush = 1'b1; step(); flush = 1'b0; step();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b want 1", frame_valid); end
        checks++; if (frame_data !== {2'b10, 4'd3, 30'h39}) begin errors++; $display("FAIL flush_frame got %h want %h", frame_data, {2'b10, 4'd3, 30'h39}); end
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", dct_count); end
        step();
        n0 = fq.size();
        flush = 1'b1; step(); flush = 1'b0;
        repeat (5) step();
        checks++; if (fq.size() !== n0 || frame_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_noop frames=%0d want %0d valid=%b", fq.size(), n0, frame_valid); end
    endtask

    task automatic test_stall_overflow();
        logic [1:0]  t2;
        logic [35:0] f1;
        f1 = {2'b01, 4'hF, 30'h15555555};
`ifdef DCT_OVERFLOW_COUNT_EN
        t2 = 2'b11;
`else
        t2 = 2'b01;
`endif
        frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            dct_code_valid = 1'b1;
            dct_code = (i < 15) ? 2'b01 : ((i < 30) ? 2'b10 : 2'b11);
            step();
            if (i == 20) begin
                checks++; if (frame_data !== f1 || frame_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_mid got %h v=%b want %h", frame_data, frame_valid, f1); end
            end
        end
        dct_code_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow got %b want 1", overflow); end
        checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL stall_count got %0d want 15", dct_count); end
        checks++; if (dct_buffer !== 30'h2AAAAAAA) begin errors++; $display("FAIL stall_buffer got %h want 2aaaaaaa", dct_buffer); end
        checks++; if (frame_data !== f1 || frame_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_end got %h v=%b want %h", frame_data, frame_valid, f1); end
`ifdef DCT_OVERFLOW_COUNT_EN
        checks++; if (overflow_count !== 8'd1) begin errors++; $display("FAIL stall_ovf_count got %0d want 1", overflow_count); end
`endif
        frame_ready = 1'b1;
        step();
        checks++; if (frame_data !== {t2, 4'hF, 30'h2AAAAAAA} || frame_valid !== 1'b1) begin errors++; $display("FAIL stall_second_frame got %h v=%b want %h", frame_data, frame_valid, {t2, 4'hF, 30'h2AAAAAAA}); end
        step();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", frame_valid); end
        trace_enable = 1'b0; step();
        trace_enable = 1'b1; step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear_on_rise got %b want 0", overflow); end
`ifdef DCT_OVERFLOW_COUNT_EN
        checks++; if (overflow_count !== 8'd0) begin errors++; $display("FAIL ovf_count_clear got %0d want 0", overflow_count); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [29:0] mb;
        logic [1:0]  c;
        int          mc;
        int          n0;
        logic [35:0] exp_q[$];
        mb = '0; mc = 0;
        frame_ready = 1'b1;
        n0 = fq.size();
        for (int i = 0; i < 60; i++) begin
            c = 2'((i * 3 + 1) % 4);
            mb = {mb[27:0], c};
            mc++;
            if (mc == 15) begin
                exp_q.push_back({2'b01, 4'hF, mb});
                mb = '0; mc = 0;
            end
            dct_code_valid = 1'b1; dct_code = c; step();
        end
        dct_code_valid = 1'b0;
        repeat (4) step();
        checks++; if (fq.size() - n0 !== 4) begin errors++; $display("FAIL b2b_frame_count got %0d want 4", fq.size() - n0); end
        for (int k = 0; k < exp_q.size() && n0 + k < fq.size(); k++) begin
            checks++; if (fq[n0 + k] !== exp_q[k]) begin errors++; $display("FAIL b2b_frame%0d got %h want %h", k, fq[n0 + k], exp_q[k]); end
            if (k > 0) begin
                checks++; if (fc[n0 + k] - fc[n0 + k - 1] !== 15) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 15", k, fc[n0 + k] - fc[n0 + k - 1]); end
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_drop got %b want 0", overflow); end
    endtask

    task automatic test_disable();
        logic [29:0] mb;
        int          n0;
        mb = '0;
        frame_ready = 1'b1;
        n0 = fq.size();
        for (int i = 0; i < 7; i++) begin
            mb = {mb[27:0], 2'(i)};
            dct_code_valid = 1'b1; dct_code = 2'(i); step();
        end
        trace_enable = 1'b0; dct_code = 2'b11;
        step(); step();
        checks++; if (frame_valid !== 1'b1 || frame_data !== {2'b10, 4'd7, mb}) begin errors++; $display("FAIL disable_flush_frame got %h v=%b want %h", frame_data, frame_valid, {2'b10, 4'd7, mb}); end
        repeat (4) step();
        checks++; if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin errors++; $display("FAIL disable_ignore got cnt=%0d buf=%h want 0", dct_count, dct_buffer); end
        checks++; if (fq.size() !== n0 + 1) begin errors++; $display("FAIL disable_one_frame got %0d want %0d", fq.size(), n0 + 1); end
        dct_code_valid = 1'b0; trace_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int n0;
        frame_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            dct_code_valid = 1'b1; dct_code = 2'b01; step();
        end
        dct_code_valid = 1'b0;
        checks++; if (dct_count !== 4'd9 || frame_valid !== 1'b1) begin errors++; $display("FAIL midreset_setup got cnt=%0d v=%b want 9/1", dct_count, frame_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin errors++; $display("FAIL midreset_buffer got cnt=%0d buf=%h want 0", dct_count, dct_buffer); end
        checks++; if (frame_valid !== 1'b0 || frame_data !== 36'd0) begin errors++; $display("FAIL midreset_slot got v=%b d=%h want 0", frame_valid, frame_data); end
        n0 = fq.size();
        frame_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (10) step();
        checks++; if (fq.size() !== n0 || frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_frame got frames=%0d v=%b want %0d/0", fq.size(), frame_valid, n0); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_flush();
        test_stall_overflow();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
